// File: rtl/pipe_hazard_ctrl.sv
// Pipeline interlock and sequencing controller for the five-stage SimpleRisc core.
// Produces PC / IF-OF / OF-EX / EX-MA load enables and bubble controls for
// load-use stalls, taken-branch squashes and multi-cycle mul/div/mod in EX,
// and keeps saturating counters of stall cycles and branch flushes.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | no multi-cycle op in flight; EX is examined for a new mul/div/mod
// BUSY  | mul/div/mod holding EX; cnt counts remaining frozen cycles
module pipe_hazard_ctrl #(
    parameter int MDU_LAT = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      of_instr,
    input  logic             of_valid,
    input  logic [31:0]      ex_instr,
    input  logic             ex_valid,
    input  logic             is_branch_taken,
    input  logic             ext_stall,
    output logic             pc_we,
    output logic             if_of_we,
    output logic             if_of_flush,
    output logic             of_ex_we,
    output logic             of_ex_flush,
    output logic             ex_ma_we,
    output logic             ex_ma_bubble,
    output logic             mdu_busy,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    localparam logic [4:0] OP_MUL  = 5'd2;
    localparam logic [4:0] OP_DIV  = 5'd3;
    localparam logic [4:0] OP_MOD  = 5'd4;
    localparam logic [4:0] OP_CMP  = 5'd5;
    localparam logic [4:0] OP_NOT  = 5'd8;
    localparam logic [4:0] OP_MOV  = 5'd9;
    localparam logic [4:0] OP_ALU_LAST = 5'd12;
    localparam logic [4:0] OP_LD   = 5'd14;
    localparam logic [4:0] OP_ST   = 5'd15;
    localparam logic [4:0] OP_CALL = 5'd19;
    localparam logic [4:0] OP_RET  = 5'd20;
    localparam logic [3:0] REG_RA  = 4'd15;

    // First frozen cycle happens in IDLE, so BUSY only needs MDU_LAT-2 more
    // frozen cycles before the release cycle.
    localparam logic [3:0] CNT_LOAD = 4'(MDU_LAT - 2);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0] flush_events_q, flush_events_d;

    logic [4:0] of_op, ex_op;
    logic       of_imm;
    logic [3:0] of_rd, of_rs1, of_rs2, ex_rd;
    logic       of_is_alu, ex_is_alu;
    logic       of_use_rs1, of_use_rs2, of_use_rd, of_use_ra;
    logic       ex_has_dst;
    logic [3:0] ex_dst;
    logic       ex_is_ld, ex_is_mdu;
    logic       load_use;
    logic       branch_take;

    logic pc_we_c, if_of_we_c, if_of_flush_c, of_ex_we_c, of_ex_flush_c;
    logic ex_ma_we_c, ex_ma_bubble_c, mdu_busy_c;

    logic unused_instr_bits;
    assign unused_instr_bits = ^{of_instr[13:0], ex_instr[26], ex_instr[21:0]};

    // Decode OF source registers, EX destination and the load-use match.
    always_comb begin
        of_op  = of_instr[31:27];
        of_imm = of_instr[26];
        of_rd  = of_instr[25:22];
        of_rs1 = of_instr[21:18];
        of_rs2 = of_instr[17:14];
        ex_op  = ex_instr[31:27];
        ex_rd  = ex_instr[25:22];

        of_is_alu = (of_op <= OP_ALU_LAST);
        ex_is_alu = (ex_op <= OP_ALU_LAST);

        // mov/not take their only register operand through rs2
        of_use_rs1 = (of_is_alu && (of_op != OP_MOV) && (of_op != OP_NOT))
                     || (of_op == OP_LD) || (of_op == OP_ST);
        of_use_rs2 = of_is_alu && !of_imm;
        of_use_rd  = (of_op == OP_ST);
        of_use_ra  = (of_op == OP_RET);

        ex_has_dst = (ex_is_alu && (ex_op != OP_CMP)) || (ex_op == OP_LD)
                     || (ex_op == OP_CALL);
        ex_dst     = (ex_op == OP_CALL) ? REG_RA : ex_rd;

        ex_is_ld  = (ex_op == OP_LD);
        ex_is_mdu = (ex_op == OP_MUL) || (ex_op == OP_DIV) || (ex_op == OP_MOD);

        load_use = ex_valid && of_valid && ex_is_ld && ex_has_dst &&
                   ((of_use_rs1 && (of_rs1 == ex_dst)) ||
                    (of_use_rs2 && (of_rs2 == ex_dst)) ||
                    (of_use_rd  && (of_rd  == ex_dst)) ||
                    (of_use_ra  && (REG_RA == ex_dst)));

        branch_take = ex_valid && is_branch_taken;
    end

    // Prioritised interlock decision, next state and counter updates.
    always_comb begin
        pc_we_c        = 1'b1;
        if_of_we_c     = 1'b1;
        if_of_flush_c  = 1'b0;
        of_ex_we_c     = 1'b1;
        of_ex_flush_c  = 1'b0;
        ex_ma_we_c     = 1'b1;
        ex_ma_bubble_c = 1'b0;
        mdu_busy_c     = 1'b0;
        state_d        = state_q;
        cnt_d          = cnt_q;
        flush_events_d = flush_events_q;

        if (ext_stall) begin
            pc_we_c    = 1'b0;
            if_of_we_c = 1'b0;
            of_ex_we_c = 1'b0;
            ex_ma_we_c = 1'b0;
            mdu_busy_c = (state_q == BUSY);
        end else if (state_q == BUSY) begin
            if (cnt_q != 4'd0) begin
                pc_we_c        = 1'b0;
                if_of_we_c     = 1'b0;
                of_ex_we_c     = 1'b0;
                ex_ma_bubble_c = 1'b1;
                mdu_busy_c     = 1'b1;
                cnt_d          = cnt_q - 4'd1;
            end else begin
                // release: EX/MA captures the result with default enables
                state_d = IDLE;
            end
        end else if (ex_valid && ex_is_mdu) begin
            pc_we_c        = 1'b0;
            if_of_we_c     = 1'b0;
            of_ex_we_c     = 1'b0;
            ex_ma_bubble_c = 1'b1;
            mdu_busy_c     = 1'b1;
            cnt_d          = CNT_LOAD;
            state_d        = BUSY;
        end else if (branch_take) begin
            if_of_flush_c = 1'b1;
            of_ex_flush_c = 1'b1;
            if (flush_events_q != '1) begin
                flush_events_d = flush_events_q + 1'b1;
            end
        end else if (load_use) begin
            pc_we_c       = 1'b0;
            if_of_we_c    = 1'b0;
            of_ex_flush_c = 1'b1;
        end

        stall_cycles_d = stall_cycles_q;
        if (!pc_we_c && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + 1'b1;
        end
    end

    // State, countdown and performance counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            cnt_q          <= 4'd0;
            stall_cycles_q <= '0;
            flush_events_q <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            stall_cycles_q <= stall_cycles_d;
            flush_events_q <= flush_events_d;
        end
    end

    // Controls are forced low for as long as reset is held.
    always_comb begin
        pc_we        = pc_we_c        && !reset;
        if_of_we     = if_of_we_c     && !reset;
        if_of_flush  = if_of_flush_c  && !reset;
        of_ex_we     = of_ex_we_c     && !reset;
        of_ex_flush  = of_ex_flush_c  && !reset;
        ex_ma_we     = ex_ma_we_c     && !reset;
        ex_ma_bubble = ex_ma_bubble_c && !reset;
        mdu_busy     = mdu_busy_c     && !reset;
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_events = flush_events_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios followed by
// random traffic, compared each cycle against a behavioural model.
module tb_pipe_hazard_ctrl;

    localparam int MDU_LAT = 4;
    localparam int CNT_W   = 16;
    localparam longint CNT_MAX = (64'd1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic [31:0]      of_instr, ex_instr;
    logic             of_valid, ex_valid, is_branch_taken, ext_stall;
    logic             pc_we, if_of_we, if_of_flush, of_ex_we, of_ex_flush;
    logic             ex_ma_we, ex_ma_bubble, mdu_busy;
    logic [CNT_W-1:0] stall_cycles, flush_events;

    pipe_hazard_ctrl #(.MDU_LAT(MDU_LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .of_instr(of_instr), .of_valid(of_valid),
        .ex_instr(ex_instr), .ex_valid(ex_valid),
        .is_branch_taken(is_branch_taken), .ext_stall(ext_stall),
        .pc_we(pc_we), .if_of_we(if_of_we), .if_of_flush(if_of_flush),
        .of_ex_we(of_ex_we), .of_ex_flush(of_ex_flush),
        .ex_ma_we(ex_ma_we), .ex_ma_bubble(ex_ma_bubble), .mdu_busy(mdu_busy),
        .stall_cycles(stall_cycles), .flush_events(flush_events)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // {pc_we, if_of_we, if_of_flush, of_ex_we, of_ex_flush, ex_ma_we, ex_ma_bubble, mdu_busy}
    logic [7:0] dut_ctrl;
    assign dut_ctrl = {pc_we, if_of_we, if_of_flush, of_ex_we, of_ex_flush,
                       ex_ma_we, ex_ma_bubble, mdu_busy};

    localparam logic [7:0] C_ZERO   = 8'b0000_0000;
    localparam logic [7:0] C_DEF    = 8'b1101_0100;
    localparam logic [7:0] C_FREEZE = 8'b0000_0111;
    localparam logic [7:0] C_BRANCH = 8'b1111_1100;
    localparam logic [7:0] C_LDUSE  = 8'b0001_1100;

    // model state: MDU occupancy expressed as cycles already spent in EX
    bit     m_active;
    int     m_age;
    longint m_stall;
    longint m_flush;
    bit     n_active;
    int     n_age;
    longint n_stall;
    longint n_flush;

    function automatic logic [31:0] mk(int op, int imm, int rd, int rs1, int rs2);
        logic [31:0] w;
        w = '0;
        w[31:27] = 5'(op);
        w[26]    = 1'(imm);
        w[25:22] = 4'(rd);
        w[21:18] = 4'(rs1);
        w[17:14] = 4'(rs2);
        return w;
    endfunction

    // Registers read by the OF instruction, straight from the ISA operand rules.
    function automatic void of_sources(input logic [31:0] ins, output int srcs[$]);
        int op;
        op = int'(ins[31:27]);
        srcs = {};
        if ((op <= 12 && op != 8 && op != 9) || op == 14 || op == 15)
            srcs.push_back(int'(ins[21:18]));
        if (op <= 12 && ins[26] == 1'b0)
            srcs.push_back(int'(ins[17:14]));
        if (op == 15)
            srcs.push_back(int'(ins[25:22]));
        if (op == 20)
            srcs.push_back(15);
    endfunction

    function automatic bit is_load_use();
        int srcs[$];
        if (!(ex_valid && of_valid && int'(ex_instr[31:27]) == 14)) return 0;
        of_sources(of_instr, srcs);
        foreach (srcs[i])
            if (srcs[i] == int'(ex_instr[25:22])) return 1;
        return 0;
    endfunction

    function automatic longint sat(longint v);
        return (v > CNT_MAX) ? CNT_MAX : v;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: evaluate the model on the current inputs, compare at the
    // falling edge, commit the model at the rising edge.
    task automatic step(input bit do_chk, input string tag);
        logic [7:0] e_ctrl;
        int op;
        @(negedge clk);
        op = int'(ex_instr[31:27]);
        n_active = m_active; n_age = m_age; n_stall = m_stall; n_flush = m_flush;
        if (reset) begin
            e_ctrl = C_ZERO;
            m_active = 0; m_age = 0; m_stall = 0; m_flush = 0;
            n_active = 0; n_age = 0; n_stall = 0; n_flush = 0;
        end else if (ext_stall) begin
            e_ctrl = {7'b0, m_active};
            n_stall = m_stall + 1;
        end else if (m_active) begin
            if (m_age + 1 < MDU_LAT) begin
                e_ctrl = C_FREEZE; n_age = m_age + 1; n_stall = m_stall + 1;
            end else begin
                e_ctrl = C_DEF; n_active = 0; n_age = 0;
            end
        end else if (ex_valid && op >= 2 && op <= 4) begin
            e_ctrl = C_FREEZE; n_active = 1; n_age = 1; n_stall = m_stall + 1;
        end else if (ex_valid && is_branch_taken) begin
            e_ctrl = C_BRANCH; n_flush = m_flush + 1;
        end else if (is_load_use()) begin
            e_ctrl = C_LDUSE; n_stall = m_stall + 1;
        end else begin
            e_ctrl = C_DEF;
        end
        if (do_chk) begin
            chk({tag, "_ctrl"},  32'(dut_ctrl), 32'(e_ctrl));
            chk({tag, "_stall"}, 32'(stall_cycles), 32'(sat(m_stall)));
            chk({tag, "_flush"}, 32'(flush_events), 32'(sat(m_flush)));
        end
        @(posedge clk);
        if (!reset) begin
            m_active = n_active; m_age = n_age; m_stall = n_stall; m_flush = n_flush;
        end
        #1;
    endtask

    task automatic idle_inputs();
        of_instr = mk(13, 0, 0, 0, 0); of_valid = 1'b1;
        ex_instr = mk(13, 0, 0, 0, 0); ex_valid = 1'b1;
        is_branch_taken = 1'b0; ext_stall = 1'b0;
    endtask

    initial begin
        int ops[12];
        int cyc;
        ops = '{0, 1, 2, 5, 8, 9, 13, 14, 15, 16, 19, 20};
        reset = 1'b1;
        idle_inputs();
        m_active = 0; m_age = 0; m_stall = 0; m_flush = 0;
        step(1, "rst");
        reset = 1'b0;
        step(1, "post_rst");

        // reset arriving during the second MDU cycle
        ex_instr = mk(2, 0, 1, 2, 3);
        step(1, "rst_mdu_c1");
        chk("rst_mdu_busy_before", 32'(mdu_busy), 32'd1);
        reset = 1'b1;
        #1;
        chk("rst_async_ctrl", 32'(dut_ctrl), 32'(C_ZERO));
        step(1, "rst_mdu_hold");
        reset = 1'b0;
        idle_inputs();
        step(1, "rst_release");

        // load-use, then a non-dependent OF instruction
        ex_instr = mk(14, 1, 3, 0, 0);
        of_instr = mk(0, 0, 1, 3, 2);
        step(1, "ld_use");
        ex_instr = mk(13, 0, 0, 0, 0);
        step(1, "ld_use_after");
        chk("ld_use_stall_cnt", 32'(stall_cycles), 32'd1);
        ex_instr = mk(14, 1, 3, 0, 0);
        of_instr = mk(0, 0, 1, 4, 2);
        step(1, "ld_nodep");
        of_instr = mk(20, 0, 0, 0, 0);
        ex_instr = mk(14, 1, 15, 0, 0);
        step(1, "ld_ret_ra");
        of_instr = mk(15, 1, 7, 1, 0);
        ex_instr = mk(14, 1, 7, 0, 0);
        step(1, "ld_st_rd");
        of_instr = mk(9, 1, 1, 7, 7);
        step(1, "ld_movimm");

        // two back-to-back multiplies
        idle_inputs();
        step(1, "pre_mul");
        ex_instr = mk(2, 0, 1, 2, 3);
        for (int i = 0; i < 2 * MDU_LAT; i++) step(1, "mul2");
        ex_instr = mk(13, 0, 0, 0, 0);
        step(1, "mul_done");

        // taken branch over a would-be load-use pattern
        ex_instr = mk(16, 0, 0, 0, 0);
        of_instr = mk(0, 0, 1, 3, 2);
        is_branch_taken = 1'b1;
        step(1, "br_taken");
        is_branch_taken = 1'b0;
        ex_instr = mk(13, 0, 0, 0, 0);
        step(1, "br_after");

        // external stall inside an MDU op
        ex_instr = mk(3, 0, 1, 2, 3);
        step(1, "div_c1");
        ext_stall = 1'b1;
        for (int i = 0; i < 3; i++) step(1, "div_xstall");
        ext_stall = 1'b0;
        for (int i = 0; i < MDU_LAT - 1; i++) step(1, "div_rest");
        ex_instr = mk(13, 0, 0, 0, 0);
        step(1, "div_done");

        // random traffic
        for (int i = 0; i < 600; i++) begin
            reset           = ($urandom_range(0, 99) == 0);
            ext_stall       = ($urandom_range(0, 9) == 0);
            is_branch_taken = ($urandom_range(0, 3) == 0);
            ex_valid        = ($urandom_range(0, 9) != 0);
            of_valid        = ($urandom_range(0, 9) != 0);
            ex_instr = mk(ops[$urandom_range(0, 11)], $urandom_range(0, 1),
                          $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
            of_instr = mk(ops[$urandom_range(0, 11)], $urandom_range(0, 1),
                          $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
            step(1, "rnd");
        end

        // stall counter saturation
        reset = 1'b0;
        idle_inputs();
        step(1, "sat_pre");
        ext_stall = 1'b1;
        cyc = (1 << CNT_W) + 5;
        for (int i = 0; i < cyc; i++) step(0, "sat");
        step(1, "sat_hold");
        chk("sat_value", 32'(stall_cycles), 32'(CNT_MAX));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Pipeline interlock and sequencing controller for the five-stage SimpleRisc core.
- Generates the write-enables and flush (bubble) controls for the PC and the IF/OF, OF/EX and EX/MA pipeline registers.
- Handles three cases: load-use stalls, taken-branch squashes, and multi-cycle mul/div/mod occupancy of EX.
- Keeps saturating performance counters for stall cycles and flush events.

Parameters:
MDU_LAT, 4, total EX occupancy in cycles for mul/div/mod; legal range 2..15
CNT_W, 16, width of performance counters

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
of_instr  in  32  instruction currently in OF stage
of_valid  in  1  OF instruction is real (not bubble)
ex_instr  in  32  instruction currently in EX stage (OF/EX register output)
ex_valid  in  1  EX instruction is real
is_branch_taken  in  1  branch unit resolved taken branch in EX
ext_stall  in  1  memory-side wait; freezes whole pipe
pc_we  out  1  PC update enable
if_of_we  out  1  IF/OF register load enable
if_of_flush  out  1  IF/OF loads nop
of_ex_we  out  1  OF/EX register load enable
of_ex_flush  out  1  OF/EX loads nop (control bus all zero)
ex_ma_we  out  1  EX/MA register load enable
ex_ma_bubble  out  1  EX/MA loads nop
mdu_busy  out  1  multi-cycle op occupying EX
stall_cycles  out  CNT_W  saturating count of cycles with pc_we=0
flush_events  out  CNT_W  saturating count of taken-branch flushes

Behaviour:
- Encoding: opcode [31:27], I [26], rd [25:22], rs1 [21:18], rs2 [17:14]; r15 = ra. nop = 13, ld = 14, st = 15, mul/div/mod = 2/3/4, cmp = 5, mov/not = 9/8, b/beq/bgt/call/ret = 18/16/17/19/20.
- OF source regs:
  - rs1 for all ALU ops except mov/not, and for ld/st.
  - rs2 when I=0 for ALU ops incl cmp and mov/not.
  - rd for st.
  - r15 for ret.
  - No sources for nop/b/beq/bgt/call.
- EX destination: rd for ALU ops (except cmp) and for ld; r15 for call; none otherwise.
- Load-use hazard, all of:
  - ex_valid and of_valid are both 1;
  - EX opcode is ld;
  - the ld rd equals any OF source.
- States: IDLE, BUSY. 4-bit down-counter cnt.
- Default (no event): all _we=1, all flush/bubble=0.
- Priority, highest first:
  1. reset: all outputs 0, state IDLE, cnt 0, counters 0. Reset mid-BUSY aborts to IDLE.
  2. ext_stall=1: all _we=0, flushes 0. State, cnt and counters frozen, except stall_cycles increments.
  3. MDU handling:
     - IDLE with ex_valid and EX opcode in {2,3,4}: pc_we=if_of_we=of_ex_we=0, ex_ma_bubble=1, mdu_busy=1, cnt<=MDU_LAT-2, next BUSY.
     - BUSY with cnt!=0: same freeze, cnt decrements.
     - BUSY with cnt==0: release with default outputs (EX/MA captures result), mdu_busy=0, next IDLE.
     - Total EX occupancy is exactly MDU_LAT cycles. Back-to-back MDU ops each take MDU_LAT.
  4. Taken branch (ex_valid and is_branch_taken): pc_we=1, if_of_flush=1, of_ex_flush=1; flush_events++.
  5. Load-use hazard: pc_we=if_of_we=0, of_ex_flush=1 (one bubble), ex_ma_we=1. Exactly 1 stall cycle.
- Interactions:
  - A branch coincident with a load-use hazard: the branch wins.
  - mdu_busy masks is_branch_taken; MDU ops are never branches.
- stall_cycles increments on every non-reset cycle with pc_we=0.
- Both counters saturate at all-ones.
- All control outputs are combinational from inputs and state; no added latency.

Test Plan:
1. Reset asserted mid-BUSY (MDU_LAT=4, cycle 2) -> next edge state IDLE, all outputs 0. After deassert with no hazard: pc_we=if_of_we=of_ex_we=ex_ma_we=1.
2. EX=ld r3; OF=add r1,r3,r2 -> one cycle pc_we=0, of_ex_flush=1. Next cycle, with EX=nop: all _we=1, stall_cycles=1. With OF=add r1,r4,r2 instead: no stall.
3. EX=mul (MDU_LAT=4) -> mdu_busy=1 for cycles 1-3, ex_ma_bubble=1 for those cycles, release on cycle 4. Second mul immediately following -> another 4 cycles; stall_cycles=6.
4. EX=beq with is_branch_taken=1 and OF=ld-dependent instr -> if_of_flush=of_ex_flush=1, pc_we=1, no load-use stall, flush_events=1.
5. ext_stall=1 for 3 cycles during BUSY -> cnt and state frozen, all _we=0. The MDU op then completes MDU_LAT cycles after start plus 3.
6. Force 2^CNT_W+5 stall cycles -> stall_cycles holds at 0xFFFF (CNT_W=16).
